// File: rtl/term_accumulator.sv
// term_accumulator: running saturating sum of three signed fixed-point terms,
// converted to IEEE-754 single precision on READ.
module term_accumulator #(
    parameter int TERM_WIDTH     = 22,
    parameter int FRAC_BITS      = 20,
    parameter int ACC_WIDTH      = 32,
    parameter int FLT_DATA_WIDTH = 32,
    parameter int N_WIDTH        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         start,
    input  logic [N_WIDTH-1:0]           n,
    input  logic signed [TERM_WIDTH-1:0] term_one,
    input  logic signed [TERM_WIDTH-1:0] term_two,
    input  logic signed [TERM_WIDTH-1:0] term_three,
    output logic                         done,
    output logic [FLT_DATA_WIDTH-1:0]    result
);

    localparam int SW      = ACC_WIDTH + 2;
    localparam int CW      = $clog2(ACC_WIDTH);
    localparam int MANT_W  = 23;
    localparam int EXP_W   = 8;
    localparam int EXP_OFF = 127 + ACC_WIDTH - 2 - FRAC_BITS;

    localparam logic [N_WIDTH-1:0] CMD_CLEAR = N_WIDTH'(0);
    localparam logic [N_WIDTH-1:0] CMD_GO    = N_WIDTH'(1);
    localparam logic [N_WIDTH-1:0] CMD_READ  = N_WIDTH'(2);

    // Symmetric clamp range keeps |acc| representable in ACC_WIDTH-1 bits.
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        ABS,
        NORM,
        PACK,
        DONE
    } state_t;

    state_t                        state_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   w_q;
    logic signed [TERM_WIDTH-1:0]  t1_q;
    logic signed [TERM_WIDTH-1:0]  t2_q;
    logic signed [TERM_WIDTH-1:0]  t3_q;
    logic                          sign_q;
    logic [ACC_WIDTH-1:0]          mag_q;
    logic [CW-1:0]                 c_q;
    logic                          done_q;
    logic [FLT_DATA_WIDTH-1:0]     result_q;

    logic signed [SW-1:0]          term_sum;
    logic signed [SW-1:0]          acc_sum;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic [ACC_WIDTH-1:0]          w_abs;
    logic [EXP_W-1:0]              exp_d;
    logic [FLT_DATA_WIDTH-1:0]     result_d;

    // Saturating next accumulator, magnitude of the read snapshot, float packing.
    always_comb begin
        term_sum = SW'(t1_q) + SW'(t2_q) + SW'(t3_q);
        acc_sum  = SW'(acc_q) + term_sum;
        if (acc_sum > SAT_MAX) begin
            acc_d = ACC_WIDTH'(SAT_MAX);
        end else if (acc_sum < SAT_MIN) begin
            acc_d = ACC_WIDTH'(SAT_MIN);
        end else begin
            acc_d = ACC_WIDTH'(acc_sum);
        end
        w_abs    = w_q[ACC_WIDTH-1] ? ACC_WIDTH'(-w_q) : ACC_WIDTH'(w_q);
        exp_d    = EXP_W'(EXP_OFF) - EXP_W'(c_q);
        result_d = {sign_q, exp_d, mag_q[ACC_WIDTH-3 -: MANT_W]};
    end

    // Command FSM with registered done/result; clk_en stalls everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            w_q      <= '0;
            t1_q     <= '0;
            t2_q     <= '0;
            t3_q     <= '0;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            c_q      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (clk_en) begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (n == CMD_CLEAR) begin
                            acc_q   <= '0;
                            state_q <= DONE;
                        end else if (n == CMD_GO) begin
                            t1_q    <= term_one;
                            t2_q    <= term_two;
                            t3_q    <= term_three;
                            state_q <= ACCUM;
                        end else if (n == CMD_READ) begin
                            w_q     <= acc_q;
                            state_q <= ABS;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    acc_q   <= acc_d;
                    state_q <= DONE;
                end
                ABS: begin
                    sign_q  <= w_q[ACC_WIDTH-1];
                    mag_q   <= w_abs;
                    c_q     <= '0;
                    state_q <= (w_abs == '0) ? PACK : NORM;
                end
                NORM: begin
                    if (mag_q[ACC_WIDTH-2]) begin
                        state_q <= PACK;
                    end else begin
                        mag_q <= mag_q << 1;
                        c_q   <= c_q + CW'(1);
                    end
                end
                PACK: begin
                    result_q <= (mag_q == '0) ? '0 : result_d;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_term_accumulator.sv
// tb_term_accumulator: directed vectors with hand-computed floats and
// latencies for term_accumulator.
module tb_term_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  n = 2'd0;
    logic [21:0] term_one = '0;
    logic [21:0] term_two = '0;
    logic [21:0] term_three = '0;
    logic        done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    term_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .start      (start),
        .n          (n),
        .term_one   (term_one),
        .term_two   (term_two),
        .term_three (term_three),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one command and count edges from the start edge to done.
    task automatic do_cmd(input logic [1:0] cmd, input logic [21:0] a,
                          input logic [21:0] b, input logic [21:0] c,
                          output int lat);
        @(negedge clk);
        start = 1'b1;
        n = cmd;
        term_one = a;
        term_two = b;
        term_three = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        term_one = '0;
        term_two = '0;
        term_three = '0;
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (lat >= 100) begin
                chk("timeout", 32'(lat), 32'd0);
                break;
            end
        end
    endtask

    // Count done samples over a number of edges (start held low).
    task automatic count_done(input int edges, output int cnt);
        cnt = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    int lat;
    int cnt;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // CLEAR, READ of zero, reserved command
        do_cmd(2'd0, 22'h0, 22'h0, 22'h0, lat);
        chk("clear_lat", 32'(lat), 32'd1);
        @(posedge clk);
        #1;
        chk("done_width", 32'(done), 32'd0);
        do_cmd(2'd2, 22'h0, 22'h0, 22'h0, lat);
        chk("read0_lat", 32'(lat), 32'd3);
        chk("read0_res", result, 32'h0000_0000);
        do_cmd(2'd3, 22'h0, 22'h0, 22'h0, lat);
        chk("rsvd_lat", 32'(lat), 32'd1);

        // 1.0 + 0.5 + 0.25 = 1.75
        do_cmd(2'd0, 22'h0, 22'h0, 22'h0, lat);
        do_cmd(2'd1, 22'h100000, 22'h080000, 22'h040000, lat);
        chk("go_lat", 32'(lat), 32'd2);
        do_cmd(2'd2, 22'h0, 22'h0, 22'h0, lat);
        chk("r175_lat", 32'(lat), 32'd14);
        chk("r175_res", result, 32'h3FE0_0000);

        // A pending done is held while clk_en is low
        do_cmd(2'd3, 22'h0, 22'h0, 22'h0, lat);
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("done_hold", 32'(done), 32'd1);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("done_rel", 32'(done), 32'd0);
        chk("rsvd_keep_res", result, 32'h3FE0_0000);

        // CLEAR leaves result untouched
        do_cmd(2'd0, 22'h0, 22'h0, 22'h0, lat);
        chk("clr_keep_res", result, 32'h3FE0_0000);

        // Two times -1.0, then +2.0 back to zero
        do_cmd(2'd1, 22'h300000, 22'h0, 22'h0, lat);
        do_cmd(2'd1, 22'h300000, 22'h0, 22'h0, lat);
        do_cmd(2'd2, 22'h0, 22'h0, 22'h0, lat);
        chk("rm2_lat", 32'(lat), 32'd13);
        chk("rm2_res", result, 32'hC000_0000);
        do_cmd(2'd1, 22'h100000, 22'h100000, 22'h0, lat);
        do_cmd(2'd2, 22'h0, 22'h0, 22'h0, lat);
        chk("rz_lat", 32'(lat), 32'd3);
        chk("rz_res", result, 32'h0000_0000);

        // Positive saturation
        do_cmd(2'd0, 22'h0, 22'h0, 22'h0, lat);
        for (int i = 0; i < 400; i++) begin
            do_cmd(2'd1, 22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, lat);
        end
        do_cmd(2'd2, 22'h0, 22'h0, 22'h0, lat);
        chk("sat_lat", 32'(lat), 32'd4);
        chk("sat_res", result, 32'h44FF_FFFF);
        do_cmd(2'd1, 22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, lat);
        do_cmd(2'd2, 22'h0, 22'h0, 22'h0, lat);
        chk("sat_hold", result, 32'h44FF_FFFF);

        // READ of 1.75 with a 5-cycle stall in NORM and busy starts
        do_cmd(2'd0, 22'h0, 22'h0, 22'h0, lat);
        do_cmd(2'd1, 22'h100000, 22'h080000, 22'h040000, lat);
        @(negedge clk);
        start = 1'b1;
        n = 2'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 2'd1;
        term_one = 22'h100000;
        lat = 0;
        for (int e = 0; e < 60; e++) begin
            clk_en = (lat >= 3 && lat < 8) ? 1'b0 : 1'b1;
            start = (lat == 1 || lat == 5 || lat == 10) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        start = 1'b0;
        clk_en = 1'b1;
        term_one = '0;
        chk("stall_lat", 32'(lat), 32'd19);
        chk("stall_res", result, 32'h3FE0_0000);
        count_done(10, cnt);
        chk("stall_extra", 32'(cnt), 32'd0);
        do_cmd(2'd2, 22'h0, 22'h0, 22'h0, lat);
        chk("stall_acc", result, 32'h3FE0_0000);

        // Reset in the middle of a READ
        do_cmd(2'd0, 22'h0, 22'h0, 22'h0, lat);
        do_cmd(2'd1, 22'h100000, 22'h0, 22'h0, lat);
        @(negedge clk);
        start = 1'b1;
        n = 2'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_res", result, 32'h0);
        rst = 1'b0;
        count_done(20, cnt);
        chk("mrst_nodone", 32'(cnt), 32'd0);
        do_cmd(2'd2, 22'h0, 22'h0, 22'h0, lat);
        chk("mrst_lat", 32'(lat), 32'd3);
        chk("mrst_acc", result, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
